// File: rtl/counter_tank.sv
// Memory Tank position counter: advances on each half minor cycle and serialises
// the current position LSB-first into the address window for the coincidence unit.
module counter_tank #(
  parameter int WIDTH     = 5,
  parameter int POSITIONS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d0,
  input  logic             d18,
  input  logic             d2,
  input  logic             d20,
  output logic             cntr,
  output logic             cntr_window,
  output logic [WIDTH-1:0] position,
  output logic             major,
  output logic             seq_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] LAST_POS = WIDTH'(POSITIONS - 1);
  localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] position_q, position_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic             major_q, major_d;
  logic             seq_err_q, seq_err_d;

  logic             adv;
  logic             win;
  logic [WIDTH-1:0] pos_inc;

  assign adv     = d0 | d18;
  assign win     = d2 | d20;
  assign pos_inc = (position_q == LAST_POS) ? '0 : position_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    position_d  = position_q;
    sreg_d      = sreg_q;
    bitcnt_d    = bitcnt_q;
    major_d     = 1'b0;
    seq_err_d   = seq_err_q;
    cntr_window = 1'b0;

    // An advance never shares its cycle with a window bit, so it gates the IDLE window.
    if (state_q == SHIFT) cntr_window = 1'b1;
    else                  cntr_window = win & ~adv;

    if (adv) begin
      position_d = pos_inc;
      sreg_d     = pos_inc;
      bitcnt_d   = '0;
      state_d    = IDLE;
      major_d    = (pos_inc == '0);
      if (state_q == SHIFT || win) seq_err_d = 1'b1;
    end else if (state_q == IDLE) begin
      if (win) begin
        sreg_d   = sreg_q >> 1;
        bitcnt_d = CW'(1);
        if (WIDTH > 1) state_d = SHIFT;
      end
    end else begin
      sreg_d   = sreg_q >> 1;
      bitcnt_d = bitcnt_q + 1'b1;
      if (bitcnt_q == LAST_BIT) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      position_q <= LAST_POS;
      sreg_q     <= '0;
      bitcnt_q   <= '0;
      major_q    <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      position_q <= position_d;
      sreg_q     <= sreg_d;
      bitcnt_q   <= bitcnt_d;
      major_q    <= major_d;
      seq_err_q  <= seq_err_d;
    end
  end

  assign cntr     = cntr_window & sreg_q[0];
  assign position = position_q;
  assign major    = major_q;
  assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_counter_tank.sv
// Directed bench for counter_tank: drives digit pulses cycle by cycle and checks
// windows, position, wrap pulse and sequencing-error behaviour against fixed values.
module tb_counter_tank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       d0 = 1'b0, d18 = 1'b0, d2 = 1'b0, d20 = 1'b0;
  logic       cntr, cntr_window, major, seq_err;
  logic [4:0] position;

  int n_checks = 0;
  int n_errors = 0;

  counter_tank #(.WIDTH(5), .POSITIONS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .d0(d0), .d18(d18), .d2(d2), .d20(d20),
    .cntr(cntr), .cntr_window(cntr_window),
    .position(position), .major(major), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit a0, input bit a18, input bit a2, input bit a20);
    d0 = a0; d18 = a18; d2 = a2; d20 = a20;
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    set_in(0, 0, 0, 0);
    check("rst_pos", position, 31);
    check("rst_cntr", cntr, 0);
    check("rst_win", cntr_window, 0);
    check("rst_major", major, 0);
    check("rst_err", seq_err, 0);
  endtask

  // One 18-cycle half minor cycle: advance at cycle 0, window at cycles 2..6.
  task automatic half_cycle(input bit second, input int exp_pos);
    for (int c = 0; c < 18; c++) begin
      set_in(c == 0 && !second, c == 0 && second, c == 2 && !second, c == 2 && second);
      if (c == 1) begin
        check($sformatf("pos@%0d", exp_pos), position, exp_pos);
        check($sformatf("major@%0d", exp_pos), major, (exp_pos == 0) ? 1 : 0);
      end
      if (c == 2) check($sformatf("major_end@%0d", exp_pos), major, 0);
      if (c >= 2 && c <= 6) begin
        check($sformatf("win@%0d.%0d", exp_pos, c - 2), cntr_window, 1);
        check($sformatf("cntr@%0d.%0d", exp_pos, c - 2), cntr, (exp_pos >> (c - 2)) & 1);
      end
      if (c == 1 || c == 7) begin
        check($sformatf("win_off@%0d.%0d", exp_pos, c), cntr_window, 0);
        check($sformatf("cntr_off@%0d.%0d", exp_pos, c), cntr, 0);
      end
      tick();
    end
  endtask

  initial begin
    tick();

    // Window before any advance carries zeros.
    do_reset();
    set_in(0, 0, 1, 0);
    check("noadv_win", cntr_window, 1);
    check("noadv_cntr0", cntr, 0);
    tick();
    for (int k = 1; k < 5; k++) begin
      set_in(0, 0, 0, 0);
      check($sformatf("noadv_cntr%0d", k), cntr, 0);
      tick();
    end

    // 34 advances: values 0..31, wrap to 0 with major pulse, then 1.
    do_reset();
    for (int k = 0; k < 34; k++) half_cycle(k[0], k % 32);
    check("no_err_run", seq_err, 0);

    // Position 5 window, explicit bit pattern.
    do_reset();
    for (int k = 0; k < 5; k++) half_cycle(k[0], k);
    begin
      bit exp_bits [5] = '{1, 0, 1, 0, 0};
      set_in(0, 1, 0, 0); tick();
      set_in(0, 0, 0, 0); tick();
      for (int k = 0; k < 5; k++) begin
        set_in(0, 0, 0, k == 0);
        check($sformatf("p5_bit%0d", k), cntr, exp_bits[k]);
        tick();
      end
      set_in(0, 0, 0, 0);
      check("p5_after", cntr_window, 0);
    end

    // Advance during SHIFT of value 7 aborts the window and sets seq_err.
    do_reset();
    for (int k = 0; k < 7; k++) half_cycle(k[0], k);
    set_in(0, 1, 0, 0); tick();
    set_in(0, 0, 0, 0);
    check("abort_pos7", position, 7);
    tick();
    set_in(0, 0, 0, 1); check("abort_b0", cntr, 1); tick();
    set_in(0, 0, 0, 0); check("abort_b1", cntr, 1); tick();
    set_in(0, 1, 0, 0);
    check("abort_b2", cntr, 1);
    check("abort_b2_win", cntr_window, 1);
    tick();
    set_in(0, 0, 0, 0);
    check("abort_cntr", cntr, 0);
    check("abort_win", cntr_window, 0);
    check("abort_err", seq_err, 1);
    check("abort_pos8", position, 8);
    tick(); tick(); tick();
    check("abort_err_sticky", seq_err, 1);
    check("abort_cntr_later", cntr, 0);

    // Advance coinciding with window open; then reset mid-window at 19.
    do_reset();
    set_in(1, 0, 1, 0);
    check("coin_win", cntr_window, 0);
    check("coin_cntr", cntr, 0);
    tick();
    set_in(0, 0, 0, 0);
    check("coin_pos", position, 0);
    check("coin_err", seq_err, 1);
    check("coin_major", major, 1);
    check("coin_win_next", cntr_window, 0);
    tick();
    for (int k = 1; k < 19; k++) half_cycle(k[0], k);
    set_in(0, 1, 0, 0); tick();
    set_in(0, 0, 0, 0); tick();
    set_in(0, 0, 0, 1);
    check("p19_b0", cntr, 1);
    check("p19_pos", position, 19);
    tick();
    set_in(0, 0, 0, 0);
    check("p19_b1", cntr, 1);
    tick();
    rst_n = 1'b0;
    set_in(1, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    set_in(0, 0, 0, 0);
    check("mid_rst_cntr", cntr, 0);
    check("mid_rst_win", cntr_window, 0);
    check("mid_rst_pos", position, 31);
    check("mid_rst_err", seq_err, 0);
    check("mid_rst_major", major, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
